// File: rtl/playback.sv
// playback: bus-mapped sample memory replayed onto data_o, with bus pass-through
module playback #(
    parameter int BASE_ADDR = 0,
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      addr_i,
    input  logic [15:0]      wdata_i,
    input  logic [15:0]      rdata_i,
    input  logic             rw_i,
    input  logic             valid_i,
    output logic [15:0]      addr_o,
    output logic [15:0]      wdata_o,
    output logic [15:0]      rdata_o,
    output logic             rw_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             playing_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [15:0] BASE = 16'(BASE_ADDR);
    localparam logic [15:0] LEN_MAX = 16'(DEPTH);
    localparam logic [15:0] TOP = 16'(DEPTH + 8);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAYING = 2'd1, DONE = 2'd2} state_t;
    state_t st, st_nxt;
    logic [PW-1:0] ptr, ptr_nxt, midx;
    logic [15:0] len, off, rd_val;
    logic loop_en, hit, rd, wr, start, stop, playing;
    logic [WIDTH-1:0] mem [DEPTH];
    assign off = addr_i - BASE;
    assign hit = valid_i && off < TOP;
    assign rd = hit && !rw_i;
    assign wr = hit && rw_i && rst_n;
    assign midx = PW'(off - 16'd8);
    assign stop = wr && off == 16'd1 && wdata_i[1];
    assign start = wr && off == 16'd1 && wdata_i[0] && !wdata_i[1];
    assign playing = st == PLAYING && !stop;
    assign rd_val = off >= 16'd8 ? 16'(mem[midx]) :
                    off == 16'd0 ? 16'(st) :
                    off == 16'd2 ? len :
                    off == 16'd3 ? {15'd0, loop_en} :
                    off == 16'd4 ? 16'(ptr) : 16'd0;
    always_comb begin
        st_nxt = st;
        ptr_nxt = ptr;
        if (stop)
            st_nxt = IDLE;
        else if (start && st != PLAYING && len != 16'd0 && len <= LEN_MAX) begin
            st_nxt = PLAYING;
            ptr_nxt = '0;
        end else if (st == PLAYING) begin
            if (16'(ptr) == len - 16'd1) begin
                ptr_nxt = loop_en ? '0 : ptr;
                st_nxt = loop_en ? PLAYING : DONE;
            end else
                ptr_nxt = ptr + PW'(1);
        end
    end
    always_ff @(posedge clk)
        if (wr && off >= 16'd8) mem[midx] <= wdata_i[WIDTH-1:0];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st <= IDLE;
            ptr <= '0;
            len <= LEN_MAX;
            loop_en <= 1'b0;
            data_o <= '0;
            playing_o <= 1'b0;
            addr_o <= '0;
            wdata_o <= '0;
            rdata_o <= '0;
            rw_o <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            st <= st_nxt;
            ptr <= ptr_nxt;
            if (wr && st != PLAYING && off == 16'd2) len <= wdata_i;
            if (wr && st != PLAYING && off == 16'd3) loop_en <= wdata_i[0];
            if (playing) data_o <= mem[ptr];
            playing_o <= playing;
            addr_o <= addr_i;
            wdata_o <= wdata_i;
            rw_o <= rw_i;
            valid_o <= valid_i;
            rdata_o <= rd ? rd_val : rdata_i;
        end
    end
endmodule

// File: tb/tb_playback.sv
// tb_playback: randomized directed bench with a register/memory reference model
module tb_playback;
    localparam int BASE = 16'h0100;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    logic clk = 1'b0;
    logic rst_n;
    logic [15:0] addr_i, wdata_i, rdata_i, addr_o, wdata_o, rdata_o;
    logic rw_i, valid_i, rw_o, valid_o, playing_o;
    logic [WIDTH-1:0] data_o;
    int n_checks = 0;
    int n_err = 0;
    logic [WIDTH-1:0] mem_m [DEPTH];
    logic [15:0] len_m, ptr_m;
    logic loop_m;
    logic [1:0] st_m;
    logic [7:0] pat [4];
    logic [WIDTH-1:0] held;
    int lenr;

    playback #(.BASE_ADDR(BASE), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i),
        .rw_i(rw_i), .valid_i(valid_i), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o),
        .rw_o(rw_o), .valid_o(valid_o), .data_o(data_o), .playing_o(playing_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_rd(input logic [15:0] a, input logic rw, input logic [15:0] rdi);
        logic [15:0] o;
        o = a - 16'(BASE);
        if (rw || o >= 16'(DEPTH + 8)) return rdi;
        if (o >= 16'd8) return 16'(mem_m[o - 16'd8]);
        case (o)
            16'd0: return 16'(st_m);
            16'd2: return len_m;
            16'd3: return {15'd0, loop_m};
            16'd4: return ptr_m;
            default: return 16'd0;
        endcase
    endfunction

    task automatic bus(input logic [15:0] a, input logic [15:0] wd, input logic rw, input logic [15:0] rdi);
        logic [15:0] exp_rd, o;
        addr_i = a;
        wdata_i = wd;
        rw_i = rw;
        valid_i = 1'b1;
        rdata_i = rdi;
        exp_rd = model_rd(a, rw, rdi);
        @(posedge clk);
        #1;
        chk("addr_o", addr_o, a);
        chk("wdata_o", wdata_o, wd);
        chk("rw_o", 16'(rw_o), 16'(rw));
        chk("valid_o", 16'(valid_o), 16'd1);
        chk("rdata_o", rdata_o, exp_rd);
        o = a - 16'(BASE);
        if (rw && o >= 16'd8 && o < 16'(DEPTH + 8)) mem_m[o - 16'd8] = wd[WIDTH-1:0];
        if (rw && st_m != 2'd1 && o == 16'd2) len_m = wd;
        if (rw && st_m != 2'd1 && o == 16'd3) loop_m = wd[0];
        valid_i = 1'b0;
        rw_i = 1'b0;
        addr_i = 16'($urandom);
        wdata_i = 16'($urandom);
        rdata_i = 16'($urandom);
    endtask

    task automatic wr(input int o, input int v);
        bus(16'(BASE + o), 16'(v), 1'b1, 16'($urandom));
    endtask

    task automatic rd(input int o);
        bus(16'(BASE + o), 16'($urandom), 1'b0, 16'($urandom));
    endtask

    task automatic play(input int len, input int first, input int n);
        for (int k = first; k < first + n; k++) begin
            @(posedge clk);
            #1;
            chk("play_data", 16'(data_o), 16'(mem_m[k % len]));
            chk("play_on", 16'(playing_o), 16'd1);
        end
    endtask

    task automatic play_end(input int len);
        @(posedge clk);
        #1;
        chk("end_data", 16'(data_o), 16'(mem_m[len - 1]));
        chk("end_off", 16'(playing_o), 16'd0);
    endtask

    task automatic idle_check(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            chk("idle_off", 16'(playing_o), 16'd0);
        end
    endtask

    initial begin
        pat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        rst_n = 1'b0;
        addr_i = 16'hBEEF;
        wdata_i = 16'h1234;
        rw_i = 1'b1;
        valid_i = 1'b0;
        rdata_i = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr_o", addr_o, 16'd0);
        chk("rst_wdata_o", wdata_o, 16'd0);
        chk("rst_rdata_o", rdata_o, 16'd0);
        chk("rst_rw_o", 16'(rw_o), 16'd0);
        chk("rst_valid_o", 16'(valid_o), 16'd0);
        chk("rst_data_o", 16'(data_o), 16'd0);
        chk("rst_playing", 16'(playing_o), 16'd0);
        rst_n = 1'b1;
        rw_i = 1'b0;
        st_m = 2'd0;
        len_m = 16'(DEPTH);
        loop_m = 1'b0;
        ptr_m = 16'd0;
        rd(0); rd(2); rd(3); rd(4); rd(5); rd(7);
        for (int i = 0; i < DEPTH; i++)
            wr(8 + i, {8'($urandom), i < 4 ? pat[i] : 8'($urandom)});
        bus(16'(BASE + 16), 16'($urandom), 1'b0, 16'h5555);
        bus(16'(BASE - 1), 16'($urandom), 1'b0, 16'h5555);
        bus(16'(BASE + 8 + DEPTH), 16'($urandom), 1'b0, 16'h5555);
        for (int i = 0; i < 4; i++) rd(8 + i);
        wr(2, 4); wr(3, 0); rd(2); rd(3);
        wr(1, 1);
        st_m = 2'd1;
        play(4, 0, 4);
        play_end(4);
        st_m = 2'd2;
        ptr_m = 16'd3;
        rd(0); rd(4);
        wr(3, 1);
        wr(1, 1);
        st_m = 2'd1;
        play(4, 0, 10);
        wr(1, 2);
        chk("stop_hold", 16'(data_o), 16'(mem_m[1]));
        chk("stop_off", 16'(playing_o), 16'd0);
        st_m = 2'd0;
        held = mem_m[1];
        rd(0);
        repeat (3) @(posedge clk);
        #1;
        chk("frozen", 16'(data_o), 16'(held));
        wr(2, 0); wr(1, 1);
        idle_check(3);
        rd(0);
        wr(2, DEPTH + 1); wr(1, 1);
        idle_check(3);
        rd(0); rd(2);
        wr(2, 4); wr(1, 3);
        idle_check(3);
        rd(0);
        lenr = $urandom_range(2, DEPTH);
        wr(3, 0); wr(2, lenr);
        wr(1, 1);
        st_m = 2'd1;
        wr(2, 1);
        chk("first_data", 16'(data_o), 16'(mem_m[0]));
        chk("first_on", 16'(playing_o), 16'd1);
        play(lenr, 1, lenr - 1);
        play_end(lenr);
        st_m = 2'd2;
        ptr_m = 16'(lenr - 1);
        rd(2); rd(4); rd(0);
        wr(3, 1); wr(2, 4);
        wr(1, 1);
        st_m = 2'd1;
        play(4, 0, 6);
        rst_n = 1'b0;
        rw_i = 1'b1;
        addr_i = 16'h00FF;
        wdata_i = 16'hAAAA;
        rdata_i = 16'h5A5A;
        @(posedge clk);
        #1;
        chk("mid_addr_o", addr_o, 16'd0);
        chk("mid_wdata_o", wdata_o, 16'd0);
        chk("mid_rdata_o", rdata_o, 16'd0);
        chk("mid_rw_o", 16'(rw_o), 16'd0);
        chk("mid_data_o", 16'(data_o), 16'd0);
        chk("mid_playing", 16'(playing_o), 16'd0);
        rst_n = 1'b1;
        rw_i = 1'b0;
        st_m = 2'd0;
        len_m = 16'(DEPTH);
        loop_m = 1'b0;
        ptr_m = 16'd0;
        rd(0); rd(2); rd(3); rd(4);
        wr(2, 4);
        wr(1, 1);
        st_m = 2'd1;
        play(4, 0, 4);
        play_end(4);
        for (int i = 0; i < 4; i++)
            chk("replay_mem", 16'(mem_m[i]), 16'(pat[i]));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
